// File: rtl/spram_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : spram_port_arbiter
//  Purpose  : Shares one single-port SPRAM wrapper between one writer and two
//             readers. At most one access is granted per cycle. Writes win by
//             default, but a pending read is forced through after MAX_WAIT
//             consecutive write grants. Readers are served round-robin. Each
//             read is tagged so the returned data is routed to its reader,
//             RD_LAT cycles after the grant.
//  Ports    : clk, rst              - clock, async active-high reset
//             wr_*_i / wr_ready_o   - write request channel
//             rdN_*_i / rdN_ready_o - read request channels (N = 0,1)
//             rdN_rsp_*_o           - read response (not backpressured)
//             mem_*_o / mem_doutb_i - SPRAM wrapper pins
//  Revision : 1.0 - initial release
// ============================================================================
module spram_port_arbiter #(
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 14,
  parameter int MAX_WAIT = 4,
  parameter int RD_LAT   = 2
) (
  input  logic              clk,
  input  logic              rst,
  // writer
  input  logic              wr_valid_i,
  output logic              wr_ready_o,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [DATA_W-1:0] wr_data_i,
  // reader 0
  input  logic              rd0_valid_i,
  output logic              rd0_ready_o,
  input  logic [ADDR_W-1:0] rd0_addr_i,
  output logic              rd0_rsp_vld_o,
  output logic [DATA_W-1:0] rd0_rsp_data_o,
  // reader 1
  input  logic              rd1_valid_i,
  output logic              rd1_ready_o,
  input  logic [ADDR_W-1:0] rd1_addr_i,
  output logic              rd1_rsp_vld_o,
  output logic [DATA_W-1:0] rd1_rsp_data_o,
  // SPRAM wrapper
  output logic [ADDR_W-1:0] mem_addra_o,
  output logic [ADDR_W-1:0] mem_addrb_o,
  output logic [DATA_W-1:0] mem_dina_o,
  output logic              mem_wea_o,
  output logic              mem_ena_o,
  output logic              mem_enb_o,
  input  logic [DATA_W-1:0] mem_doutb_i
);

  localparam logic [3:0] c_max_wait = 4'(MAX_WAIT);

  // Registered state
  logic              rr_ptr_q, rr_ptr_d;         // 0: rd0 preferred, 1: rd1 preferred
  logic [3:0]        starve_cnt_q, starve_cnt_d; // write grants while a read waits
  logic [RD_LAT-1:0] pipe_vld_q;                 // response tag pipeline: valid
  logic [RD_LAT-1:0] pipe_id_q;                  // response tag pipeline: reader id

  // Combinational grant decision
  logic w_rd_any;
  logic w_force_rd;
  logic w_gnt_wr;
  logic w_gnt_rd0;
  logic w_gnt_rd1;
  logic w_gnt_rd;

  always_comb begin
    w_rd_any   = rd0_valid_i | rd1_valid_i;
    w_force_rd = (starve_cnt_q == c_max_wait);
    w_gnt_wr   = 1'b0;
    w_gnt_rd0  = 1'b0;
    w_gnt_rd1  = 1'b0;
    // Grants are suppressed for the whole time reset is high, not only at edges.
    if (!rst) begin
      if (w_rd_any && (!wr_valid_i || w_force_rd)) begin
        if (rd0_valid_i && rd1_valid_i) begin
          w_gnt_rd0 = ~rr_ptr_q;
          w_gnt_rd1 = rr_ptr_q;
        end else begin
          w_gnt_rd0 = rd0_valid_i;
          w_gnt_rd1 = rd1_valid_i;
        end
      end else begin
        w_gnt_wr = wr_valid_i;
      end
    end
    w_gnt_rd = w_gnt_rd0 | w_gnt_rd1;
  end

  // Memory pins: unused buses are held at zero rather than floating the request.
  always_comb begin
    mem_wea_o   = w_gnt_wr;
    mem_ena_o   = w_gnt_wr;
    mem_enb_o   = w_gnt_rd;
    mem_addra_o = w_gnt_wr ? wr_addr_i : '0;
    mem_dina_o  = w_gnt_wr ? wr_data_i : '0;
    mem_addrb_o = '0;
    if (w_gnt_rd0) begin
      mem_addrb_o = rd0_addr_i;
    end else if (w_gnt_rd1) begin
      mem_addrb_o = rd1_addr_i;
    end
  end

  assign wr_ready_o  = w_gnt_wr;
  assign rd0_ready_o = w_gnt_rd0;
  assign rd1_ready_o = w_gnt_rd1;

  // Next-state for arbitration state
  always_comb begin
    rr_ptr_d     = rr_ptr_q;
    starve_cnt_d = starve_cnt_q;
    if (w_gnt_rd) begin
      rr_ptr_d = ~rr_ptr_q;
    end
    // The counter only measures an unbroken run of writes that overtook a read.
    if (w_gnt_rd || !w_rd_any) begin
      starve_cnt_d = 4'd0;
    end else if (w_gnt_wr && (starve_cnt_q < c_max_wait)) begin
      starve_cnt_d = starve_cnt_q + 4'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr_q     <= 1'b0;
      starve_cnt_q <= 4'd0;
      pipe_vld_q   <= '0;
      pipe_id_q    <= '0;
    end else begin
      rr_ptr_q      <= rr_ptr_d;
      starve_cnt_q  <= starve_cnt_d;
      pipe_vld_q[0] <= w_gnt_rd;
      pipe_id_q[0]  <= w_gnt_rd1;
      // Tag travels alongside the memory's registered read path.
      for (int i = 1; i < RD_LAT; i++) begin
        pipe_vld_q[i] <= pipe_vld_q[i-1];
        pipe_id_q[i]  <= pipe_id_q[i-1];
      end
    end
  end

  // Response routing from the last tag stage
  always_comb begin
    rd0_rsp_vld_o  = pipe_vld_q[RD_LAT-1] & ~pipe_id_q[RD_LAT-1];
    rd1_rsp_vld_o  = pipe_vld_q[RD_LAT-1] &  pipe_id_q[RD_LAT-1];
    rd0_rsp_data_o = rd0_rsp_vld_o ? mem_doutb_i : '0;
    rd1_rsp_data_o = rd1_rsp_vld_o ? mem_doutb_i : '0;
  end

endmodule
`default_nettype wire

// File: tb/tb_spram_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_spram_port_arbiter
//  Purpose  : Self-checking bench for spram_port_arbiter. A small SPRAM
//             wrapper model provides doutb with a 2-cycle registered read.
//             A reference model tracks grants, starvation, round-robin order
//             and expected responses in a queue.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_spram_port_arbiter;

  localparam int DATA_W   = 16;
  localparam int ADDR_W   = 14;
  localparam int MAX_WAIT = 4;
  localparam int RD_LAT   = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic              wr_valid, wr_ready;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              rd0_valid, rd0_ready, rd0_rsp_vld;
  logic [ADDR_W-1:0] rd0_addr;
  logic [DATA_W-1:0] rd0_rsp_data;
  logic              rd1_valid, rd1_ready, rd1_rsp_vld;
  logic [ADDR_W-1:0] rd1_addr;
  logic [DATA_W-1:0] rd1_rsp_data;
  logic [ADDR_W-1:0] mem_addra, mem_addrb;
  logic [DATA_W-1:0] mem_dina, mem_doutb;
  logic              mem_wea, mem_ena, mem_enb;

  always #5 clk = ~clk;

  spram_port_arbiter #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .MAX_WAIT(MAX_WAIT), .RD_LAT(RD_LAT)
  ) dut (
    .clk(clk), .rst(rst),
    .wr_valid_i(wr_valid), .wr_ready_o(wr_ready), .wr_addr_i(wr_addr), .wr_data_i(wr_data),
    .rd0_valid_i(rd0_valid), .rd0_ready_o(rd0_ready), .rd0_addr_i(rd0_addr),
    .rd0_rsp_vld_o(rd0_rsp_vld), .rd0_rsp_data_o(rd0_rsp_data),
    .rd1_valid_i(rd1_valid), .rd1_ready_o(rd1_ready), .rd1_addr_i(rd1_addr),
    .rd1_rsp_vld_o(rd1_rsp_vld), .rd1_rsp_data_o(rd1_rsp_data),
    .mem_addra_o(mem_addra), .mem_addrb_o(mem_addrb), .mem_dina_o(mem_dina),
    .mem_wea_o(mem_wea), .mem_ena_o(mem_ena), .mem_enb_o(mem_enb),
    .mem_doutb_i(mem_doutb)
  );

  // SPRAM wrapper model: registered address stage plus output register.
  logic [DATA_W-1:0] mem_array [0:(1<<ADDR_W)-1];
  logic [DATA_W-1:0] r_rq1 = '0, r_rq2 = '0;
  always @(posedge clk) begin
    if (mem_enb) r_rq1 <= mem_array[mem_addrb];
    r_rq2 <= r_rq1;
    if (mem_ena && mem_wea) mem_array[mem_addra] <= mem_dina;
  end
  assign mem_doutb = r_rq2;

  // Reference model state
  typedef struct {
    int              due;
    int              id;
    logic [DATA_W-1:0] data;
  } rsp_t;
  rsp_t              sb[$];
  logic [DATA_W-1:0] ref_mem [0:(1<<ADDR_W)-1];
  int                m_starve = 0;
  int                m_rr     = 0;
  int                cyc      = 0;
  int                n_tests  = 0;
  int                n_fail   = 0;
  int                last_g   = 0;   // 0 none, 1 write, 2 rd0, 3 rd1
  int                first_g;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d: got 0x%0h, expected 0x%0h", tag, cyc, got, exp);
    end
  endtask

  // One clock cycle: drive at negedge, check outputs, advance the model.
  task automatic step(input logic r, input logic wv, input logic [ADDR_W-1:0] wa,
                      input logic [DATA_W-1:0] wd, input logic r0v, input logic [ADDR_W-1:0] r0a,
                      input logic r1v, input logic [ADDR_W-1:0] r1a);
    int   g;
    logic e_v0, e_v1;
    logic [DATA_W-1:0] e_d0, e_d1;
    @(negedge clk);
    rst = r; wr_valid = wv; wr_addr = wa; wr_data = wd;
    rd0_valid = r0v; rd0_addr = r0a; rd1_valid = r1v; rd1_addr = r1a;
    #1;
    if (r) g = 0;
    else if ((r0v || r1v) && (!wv || m_starve == MAX_WAIT))
      g = (r0v && r1v) ? 2 + m_rr : (r0v ? 2 : 3);
    else if (wv) g = 1;
    else g = 0;

    e_v0 = 1'b0; e_v1 = 1'b0; e_d0 = '0; e_d1 = '0;
    if (r) sb.delete();
    else if (sb.size() > 0 && sb[0].due == cyc) begin
      if (sb[0].id == 0) begin e_v0 = 1'b1; e_d0 = sb[0].data; end
      else begin e_v1 = 1'b1; e_d1 = sb[0].data; end
      void'(sb.pop_front());
    end

    check_eq("wr_ready",  wr_ready,  g == 1);
    check_eq("rd0_ready", rd0_ready, g == 2);
    check_eq("rd1_ready", rd1_ready, g == 3);
    check_eq("mem_wea",   mem_wea,   g == 1);
    check_eq("mem_ena",   mem_ena,   g == 1);
    check_eq("mem_enb",   mem_enb,   g >= 2);
    check_eq("mem_addra", mem_addra, (g == 1) ? wa : '0);
    check_eq("mem_dina",  mem_dina,  (g == 1) ? wd : '0);
    check_eq("mem_addrb", mem_addrb, (g == 2) ? r0a : ((g == 3) ? r1a : '0));
    check_eq("rd0_rsp_vld",  rd0_rsp_vld,  e_v0);
    check_eq("rd1_rsp_vld",  rd1_rsp_vld,  e_v1);
    check_eq("rd0_rsp_data", rd0_rsp_data, e_d0);
    check_eq("rd1_rsp_data", rd1_rsp_data, e_d1);
    last_g = g;

    if (r) begin
      m_starve = 0; m_rr = 0;
    end else begin
      if (g == 1) ref_mem[wa] = wd;
      if (g >= 2) begin
        sb.push_back('{due: cyc + RD_LAT, id: g - 2, data: ref_mem[(g == 2) ? r0a : r1a]});
        m_rr = 1 - m_rr;
      end
      if (g >= 2 || !(r0v || r1v)) m_starve = 0;
      else if (g == 1 && m_starve < MAX_WAIT) m_starve++;
    end
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0, '0, 1'b0, '0, 1'b0, '0);
  endtask

  initial begin
    rst = 1'b1; wr_valid = 1'b0; wr_addr = '0; wr_data = '0;
    rd0_valid = 1'b0; rd0_addr = '0; rd1_valid = 1'b0; rd1_addr = '0;
    for (int i = 0; i < (1 << ADDR_W); i++) begin
      mem_array[i] = '0;
      ref_mem[i]   = '0;
    end

    // Reset: requests present but nothing may be granted
    step(1'b1, 1'b1, 14'h5, 16'h1234, 1'b1, 14'h6, 1'b1, 14'h7);
    step(1'b1, 1'b0, '0, '0, 1'b0, '0, 1'b0, '0);
    idle(2);

    // Lone read after write of 0xBEEF to 0x0010
    step(1'b0, 1'b1, 14'h0010, 16'hBEEF, 1'b0, '0, 1'b0, '0);
    step(1'b0, 1'b0, '0, '0, 1'b1, 14'h0010, 1'b0, '0);
    check_eq("t1_grant", last_g, 2);
    idle(1);
    check_eq("t1_no_rsp_yet", rd0_rsp_vld, 1'b0);
    idle(1);
    check_eq("t1_rsp_vld",  rd0_rsp_vld, 1'b1);
    check_eq("t1_rsp_data", rd0_rsp_data, 16'hBEEF);
    check_eq("t1_rd1_quiet", rd1_rsp_vld, 1'b0);
    idle(2);

    // Write priority with starvation relief: W W W W R, repeating
    for (int i = 0; i < 15; i++) begin
      step(1'b0, 1'b1, 14'(20 + i), 16'(16'hA000 + i), 1'b1, 14'h0010, 1'b0, '0);
      check_eq("t2_pattern", last_g, ((i % 5) == 4) ? 2 : 1);
    end
    idle(3);

    // Round-robin between two readers, no writes
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 1'b0, '0, '0, 1'b1, 14'(20 + i), 1'b1, 14'(30 - i));
      if (i == 0) first_g = last_g;
      else check_eq("t3_alternate", last_g, ((i % 2) == 0) ? first_g : 5 - first_g);
    end
    idle(3);

    // Reset one cycle after an rd1 grant drops the response
    step(1'b0, 1'b0, '0, '0, 1'b0, '0, 1'b1, 14'h0010);
    check_eq("t5_rd1_grant", last_g, 3);
    step(1'b1, 1'b1, 14'h1, 16'h1, 1'b1, 14'h2, 1'b1, 14'h3);
    step(1'b1, 1'b0, '0, '0, 1'b0, '0, 1'b0, '0);
    check_eq("t5_rd1_dropped", rd1_rsp_vld, 1'b0);
    step(1'b0, 1'b0, '0, '0, 1'b1, 14'h21, 1'b1, 14'h22);
    check_eq("t5_rd0_first", last_g, 2);
    idle(3);

    // Idle: no activity, and the starvation count stays clear
    idle(6);
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b1, 14'(40 + i), 16'(16'hC000 + i), 1'b1, 14'h0014, 1'b0, '0);
      check_eq("t6_pattern", last_g, (i == 4) ? 2 : 1);
    end
    idle(3);

    // Randomized traffic with occasional reset
    for (int i = 0; i < 10000; i++) begin
      step(($urandom_range(0, 499) == 0),
           1'($urandom_range(0, 1)), 14'($urandom_range(0, 15)), 16'($urandom),
           1'($urandom_range(0, 1)), 14'($urandom_range(0, 15)),
           1'($urandom_range(0, 1)), 14'($urandom_range(0, 15)));
      check_eq("rand_onehot", 32'(wr_ready) + 32'(rd0_ready) + 32'(rd1_ready) <= 1, 1);
    end
    idle(4);
    check_eq("sb_drained", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
